// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-stage stall/flush, E-stage forwarding selects,
// data-memory wait sequencing with a timeout watchdog and a saturating stall counter.
module hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic [4:0]       rs1_E,
  input  logic [4:0]       rs2_E,
  input  logic [4:0]       rd_E,
  input  logic             reg_wr_E,
  input  logic             mem_rd_E,
  input  logic [4:0]       rd_M,
  input  logic             reg_wr_M,
  input  logic [4:0]       rd_W,
  input  logic             reg_wr_W,
  input  logic             br_taken_E,
  input  logic             mem_req_M,
  input  logic             mem_ready,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_W,
  output logic [1:0]       fwd_a_E,
  output logic [1:0]       fwd_b_E,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {StRun, StWait, StErr} state_e;

  localparam logic [15:0] MaxWait = 16'(MAX_WAIT);

  state_e           state_q, state_d;
  logic [15:0]      wait_cnt_q, wait_cnt_d;
  logic [15:0]      wait_inc;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             memwait;
  logic             loaduse;

  assign memwait = (mem_req_M && !mem_ready) || (state_q == StErr);
  assign loaduse = mem_rd_E && reg_wr_E && (rd_E != 5'd0) &&
                   ((rd_E == rs1_D) || (rd_E == rs2_D));

  // Memory wait wins over branch and load-use; those are re-evaluated once released.
  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    stall_E = 1'b0;
    stall_M = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    flush_W = 1'b0;
    if (memwait) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      stall_E = 1'b1;
      stall_M = 1'b1;
      flush_W = 1'b1;
    end else if (br_taken_E) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
    end else if (loaduse) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      flush_E = 1'b1;
    end
  end

  always_comb begin
    fwd_a_E = 2'b00;
    fwd_b_E = 2'b00;
    if (reg_wr_M && (rd_M != 5'd0) && (rd_M == rs1_E)) begin
      fwd_a_E = 2'b01;
    end else if (reg_wr_W && (rd_W != 5'd0) && (rd_W == rs1_E)) begin
      fwd_a_E = 2'b10;
    end
    if (reg_wr_M && (rd_M != 5'd0) && (rd_M == rs2_E)) begin
      fwd_b_E = 2'b01;
    end else if (reg_wr_W && (rd_W != 5'd0) && (rd_W == rs2_E)) begin
      fwd_b_E = 2'b10;
    end
  end

  assign wait_inc = wait_cnt_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StRun: begin
        wait_cnt_d = 16'd0;
        if (mem_req_M && !mem_ready) state_d = StWait;
      end
      StWait: begin
        if (mem_ready) begin
          state_d    = StRun;
          wait_cnt_d = 16'd0;
        end else begin
          wait_cnt_d = wait_inc;
          if (wait_inc == MaxWait) state_d = StErr;
        end
      end
      StErr: ;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_F && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StRun;
      wait_cnt_q  <= 16'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_err      = (state_q == StErr);
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model of the hazard rules.
module tb_hazard_ctrl;

  localparam int unsigned TbMaxWait = 4;
  localparam int unsigned TbCntW    = 4;
  localparam int          CntMax    = (1 << TbCntW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic       reg_wr_E, mem_rd_E, reg_wr_M, reg_wr_W, br_taken_E, mem_req_M, mem_ready;
  logic       stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W, mem_err;
  logic [1:0] fwd_a_E, fwd_b_E;
  logic [TbCntW-1:0] stall_cycles;

  hazard_ctrl #(.MAX_WAIT(TbMaxWait), .CNT_W(TbCntW)) dut (
    .clk(clk), .reset(reset),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
    .rd_E(rd_E), .reg_wr_E(reg_wr_E), .mem_rd_E(mem_rd_E),
    .rd_M(rd_M), .reg_wr_M(reg_wr_M), .rd_W(rd_W), .reg_wr_W(reg_wr_W),
    .br_taken_E(br_taken_E), .mem_req_M(mem_req_M), .mem_ready(mem_ready),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W),
    .fwd_a_E(fwd_a_E), .fwd_b_E(fwd_b_E), .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  // {stall F,D,E,M, flush D,E,W, fwd_a, fwd_b, mem_err}
  logic [11:0] obs;
  assign obs = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
                fwd_a_E, fwd_b_E, mem_err};

  int vectors     = 0;
  int miscompares = 0;

  // Model: the outstanding access is described by how many unready cycles it has waited.
  bit m_err;
  bit m_waiting;
  int m_waits;
  int m_stalls;
  logic [11:0]       exp_vec;
  logic [TbCntW-1:0] exp_cnt;
  logic              exp_stall;

  function automatic logic [1:0] fwd_model(input logic [4:0] rs);
    if (reg_wr_M && rd_M != 0 && rd_M == rs) return 2'b01;
    if (reg_wr_W && rd_W != 0 && rd_W == rs) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_eval();
    logic mw, lu;
    logic [6:0] sf;
    mw = (mem_req_M && !mem_ready) || m_err;
    lu = mem_rd_E && reg_wr_E && rd_E != 0 && (rd_E == rs1_D || rd_E == rs2_D);
    if (mw)              sf = 7'b1111_001;
    else if (br_taken_E) sf = 7'b0000_110;
    else if (lu)         sf = 7'b1100_010;
    else                 sf = 7'b0000_000;
    exp_stall = sf[6];
    exp_vec   = {sf, fwd_model(rs1_E), fwd_model(rs2_E), m_err};
    exp_cnt   = TbCntW'(m_stalls);
  endtask

  task automatic model_clock();
    model_eval();
    if (reset) begin
      m_err = 0; m_waiting = 0; m_waits = 0; m_stalls = 0;
    end else begin
      if (exp_stall && m_stalls < CntMax) m_stalls++;
      if (!m_err) begin
        if (!m_waiting) begin
          if (mem_req_M && !mem_ready) begin
            m_waiting = 1;
            m_waits   = 0;
          end
        end else if (mem_ready) begin
          m_waiting = 0;
        end else begin
          m_waits++;
          if (m_waits == TbMaxWait) begin
            m_err     = 1;
            m_waiting = 0;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_M = 0; rd_W = 0;
    reg_wr_E = 0; mem_rd_E = 0; reg_wr_M = 0; reg_wr_W = 0;
    br_taken_E = 0; mem_req_M = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic set_loaduse(input logic [4:0] rd);
    mem_rd_E = 1; reg_wr_E = 1; rd_E = rd; rs2_D = 5;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    m_err = 0; m_waiting = 0; m_waits = 0; m_stalls = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) reset = 0;
      #1; model_eval(); vectors++;
      if (obs !== exp_vec || stall_cycles !== exp_cnt || obs !== 12'h000) begin
        miscompares++;
        $display("FAIL reset cyc%0d: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                 i, obs, stall_cycles, exp_vec, exp_cnt);
      end
      tick();
    end
  endtask

  task automatic test_loaduse();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      if (i == 0) set_loaduse(5);
      if (i == 2) set_loaduse(0);
      #1; model_eval(); vectors++;
      if (obs !== exp_vec || stall_cycles !== exp_cnt) begin
        miscompares++;
        $display("FAIL loaduse cyc%0d: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                 i, obs, stall_cycles, exp_vec, exp_cnt);
      end
      vectors++;
      if ((i == 0 && {stall_F, stall_D, flush_E} !== 3'b111) ||
          (i != 0 && stall_F !== 1'b0) || (i != 0 && stall_cycles !== 4'd1)) begin
        miscompares++;
        $display("FAIL loaduse_fixed cyc%0d: got stall_F=%b flush_E=%b cnt=%0d",
                 i, stall_F, flush_E, stall_cycles);
      end
      tick();
    end
  endtask

  task automatic test_branch();
    do_reset();
    idle_inputs();
    set_loaduse(5);
    br_taken_E = 1;
    #1; model_eval(); vectors++;
    if (obs !== exp_vec || {flush_D, flush_E, stall_F} !== 3'b110) begin
      miscompares++;
      $display("FAIL branch: got ctl=%b, want ctl=%b", obs, exp_vec);
    end
    tick();
  endtask

  task automatic test_forwarding();
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      rs1_E = 7; rs2_E = 9; rd_M = 7; rd_W = 7; reg_wr_M = 1; reg_wr_W = 1;
      if (i == 1) reg_wr_M = 0;
      if (i == 2) begin rd_M = 0; rd_W = 0; end
      if (i == 3) begin rd_M = 9; rs2_E = 7; end
      #1; model_eval(); vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL fwd case%0d: got fa=%b fb=%b, want ctl=%b", i, fwd_a_E, fwd_b_E, exp_vec);
      end
      tick();
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      if (i < 4) begin
        mem_req_M = 1; br_taken_E = 1; mem_ready = (i == 3);
      end
      #1; model_eval(); vectors++;
      if (obs !== exp_vec || stall_cycles !== exp_cnt) begin
        miscompares++;
        $display("FAIL memwait cyc%0d: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                 i, obs, stall_cycles, exp_vec, exp_cnt);
      end
      tick();
    end
    #1; vectors++;
    if (stall_cycles !== 4'd3 || mem_err !== 1'b0 || stall_M !== 1'b0) begin
      miscompares++;
      $display("FAIL memwait_total: got cnt=%0d err=%b, want cnt=3 err=0", stall_cycles, mem_err);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < TbMaxWait + 4; i++) begin
      idle_inputs();
      mem_req_M = 1;
      mem_ready = (i == TbMaxWait + 3);
      #1; model_eval(); vectors++;
      if (obs !== exp_vec || stall_cycles !== exp_cnt ||
          mem_err !== (i > TbMaxWait)) begin
        miscompares++;
        $display("FAIL timeout cyc%0d: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                 i, obs, stall_cycles, exp_vec, exp_cnt);
      end
      tick();
    end
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
    #1; model_eval(); vectors++;
    if (obs !== exp_vec || mem_err !== 1'b0 || stall_cycles !== 4'd0) begin
      miscompares++;
      $display("FAIL timeout_reset: got ctl=%b cnt=%0d, want ctl=%b cnt=0",
               obs, stall_cycles, exp_vec);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    idle_inputs();
    set_loaduse(5);
    for (int i = 0; i < 20; i++) begin
      #1; model_eval(); vectors++;
      if (obs !== exp_vec || stall_cycles !== exp_cnt) begin
        miscompares++;
        $display("FAIL sat cyc%0d: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                 i, obs, stall_cycles, exp_vec, exp_cnt);
      end
      tick();
    end
    idle_inputs();
    #1; vectors++;
    if (stall_cycles !== 4'd15) begin
      miscompares++;
      $display("FAIL sat_final: got cnt=%0d, want 15", stall_cycles);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 39) == 0);
      rs1_D      = 5'($urandom_range(0, 3));
      rs2_D      = 5'($urandom_range(0, 3));
      rs1_E      = 5'($urandom_range(0, 3));
      rs2_E      = 5'($urandom_range(0, 3));
      rd_E       = 5'($urandom_range(0, 3));
      rd_M       = 5'($urandom_range(0, 3));
      rd_W       = 5'($urandom_range(0, 3));
      reg_wr_E   = 1'($urandom);
      mem_rd_E   = 1'($urandom);
      reg_wr_M   = 1'($urandom);
      reg_wr_W   = 1'($urandom);
      br_taken_E = ($urandom_range(0, 3) == 0);
      mem_req_M  = ($urandom_range(0, 2) == 0);
      mem_ready  = ($urandom_range(0, 2) != 0);
      #1; model_eval(); vectors++;
      if (obs !== exp_vec || stall_cycles !== exp_cnt) begin
        miscompares++;
        $display("FAIL random cyc%0d: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                 i, obs, stall_cycles, exp_vec, exp_cnt);
      end
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    @(negedge clk);
    test_reset();
    test_loaduse();
    test_branch();
    test_forwarding();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
